// File: rtl/mem_master.sv
// mem_master: arbitrating fetch/data bus initiator for a start/ready word memory
module mem_master #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [2*DW-1:0] if_instr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_start,
  output logic          mem_rwn,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state, state_nx;
  logic kind_fetch, we, idx, done, tout, last;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [TW-1:0] tcnt;
  assign mem_start = state == ISSUE && mem_ready;
  assign mem_addr = addr + AW'(idx);
  assign mem_rwn = kind_fetch | ~we;
  assign mem_wdata = wdata;
  assign busy = state != IDLE;
  assign if_ack = state == ACK && kind_fetch;
  assign d_ack = state == ACK && !kind_fetch;
  always_comb begin
    done = state == WAIT && mem_ready;
    tout = state == WAIT && !mem_ready && tcnt == TW'(TIMEOUT - 1);
    last = !(kind_fetch && !idx);
    state_nx = state == IDLE  ? ((d_req || if_req) ? ISSUE : IDLE) :
               state == ISSUE ? (mem_ready ? WAIT : ISSUE) :
               state == WAIT  ? ((tout || (done && last)) ? ACK : done ? ISSUE : WAIT) :
                                IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      kind_fetch <= 1'b0;
      we <= 1'b0;
      idx <= 1'b0;
      addr <= '0;
      wdata <= '0;
      tcnt <= '0;
      if_instr <= '0;
      d_rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
      if (state == IDLE && (d_req || if_req)) begin
        kind_fetch <= !d_req;
        we <= d_req && d_we;
        addr <= d_req ? d_addr : if_addr;
        wdata <= d_wdata;
        idx <= 1'b0;
      end
      if (tout) err <= 1'b1;
      if (done && !last) begin
        if_instr[2*DW-1:DW] <= mem_rdata;
        idx <= 1'b1;
      end
      if (done && last && kind_fetch) if_instr[DW-1:0] <= mem_rdata;
      if (done && !kind_fetch && !we) d_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: randomized self-checking bench with a word memory model and latency/data reference
module tb_mem_master;
  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [7:0] if_addr = '0, d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic if_ack, d_ack, mem_start, mem_rwn, mem_ready, busy, err;
  logic [31:0] if_instr;
  logic [15:0] d_rdata, mem_wdata, mem_rdata;
  logic [7:0] mem_addr;
  int errors = 0, checks = 0;
  logic [15:0] mem [256];
  logic [15:0] shadow [256];
  logic [7:0] mcnt;
  logic [15:0] mrd;
  logic hang = 1'b0;
  logic [8:0] starts [$];
  logic [31:0] exp_instr = '0;
  logic [15:0] exp_rdata = '0;
  logic exp_err = 1'b0;

  mem_master dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  assign mem_ready = mcnt == 8'd0;
  assign mem_rdata = mrd;
  always @(posedge clk) begin
    if (reset) mcnt <= 8'd0;
    else if (mem_start) begin
      mcnt <= hang ? 8'd60 : {6'd0, mem_addr[1:0]} + 8'd1;
      if (mem_rwn) mrd <= mem[mem_addr];
      else mem[mem_addr] <= mem_wdata;
      starts.push_back({mem_rwn, mem_addr});
    end else if (mcnt != 8'd0) mcnt <= mcnt - 8'd1;
  end

  task automatic check_outputs(input string name);
    checks++;
    if ({busy, mem_start, mem_rwn, mem_addr, mem_wdata, if_ack, d_ack, if_instr, d_rdata, err} !==
        {1'b0, 1'b0, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL %s: busy=%b start=%b rwn=%b addr=%h wdata=%h acks=%b%b instr=%h rdata=%h err=%b, required all at reset values",
               name, busy, mem_start, mem_rwn, mem_addr, mem_wdata, if_ack, d_ack, if_instr, d_rdata, err);
    end
  endtask

  task automatic check_starts(input string name, input logic [8:0] e0, input logic [8:0] e1, input int n);
    bit ok;
    ok = starts.size() == n && starts[0] === e0 && (n < 2 || starts[1] === e1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s starts: got %0d strobes first=%h, required %0d strobes {rwn,addr}=%h,%h",
               name, starts.size(), starts.size() > 0 ? starts[0] : 9'h0, n, e0, e1);
    end
  endtask

  task automatic run(input string name, input bit fetch, input bit we, input logic [7:0] a, input logic [15:0] wd);
    logic [7:0] a1;
    int n, k;
    bit busy_ok;
    a1 = a + 8'd1;
    n = fetch ? int'(a[1:0]) + int'(a1[1:0]) + 7 : int'(a[1:0]) + 4;
    if (fetch) exp_instr = {shadow[a], shadow[a1]};
    else if (we) shadow[a] = wd;
    else exp_rdata = shadow[a];
    starts.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s idle busy: got %b, required 0", name, busy); end
    if (fetch) begin if_req = 1'b1; if_addr = a; end
    else begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
    k = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (!(if_ack || d_ack) && k < 60);
    checks++;
    if (k != n) begin errors++; $display("FAIL %s latency: got ack at c%0d, required c%0d", name, k, n); end
    checks++;
    if ({if_ack, d_ack} !== {fetch, !fetch}) begin
      errors++; $display("FAIL %s ack kind: got if_ack=%b d_ack=%b, required %b %b", name, if_ack, d_ack, fetch, !fetch);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL %s busy: dropped during access, required high c1..c%0d", name, n); end
    checks++;
    if (if_instr !== exp_instr) begin errors++; $display("FAIL %s if_instr: got %h, required %h", name, if_instr, exp_instr); end
    checks++;
    if (d_rdata !== exp_rdata) begin errors++; $display("FAIL %s d_rdata: got %h, required %h", name, d_rdata, exp_rdata); end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL %s err: got %b, required %b", name, err, exp_err); end
    check_starts(name, {fetch | ~we, a}, {1'b1, a1}, fetch ? 2 : 1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    run("fetch0", 1'b1, 1'b0, 8'd0, 16'd0);
    checks++;
    if (if_instr !== 32'h68840004) begin errors++; $display("FAIL fetch0 preload: got %h, required 68840004", if_instr); end
  endtask

  task automatic test_data();
    run("read245", 1'b0, 1'b0, 8'd245, 16'd0);
    checks++;
    if (d_rdata !== 16'h0008) begin errors++; $display("FAIL read245 value: got %h, required 0008", d_rdata); end
    run("write3", 1'b0, 1'b1, 8'd3, 16'hBEEF);
    run("read3", 1'b0, 1'b0, 8'd3, 16'd0);
    checks++;
    if (d_rdata !== 16'hBEEF) begin errors++; $display("FAIL read3 value: got %h, required beef", d_rdata); end
  endtask

  task automatic test_contention();
    logic [7:0] ad, af, af1;
    int k, nd, nf, kd;
    ad = 8'd6;
    af = 8'd9;
    af1 = af + 8'd1;
    nd = int'(ad[1:0]) + 4;
    nf = nd + 1 + int'(af[1:0]) + int'(af1[1:0]) + 7;
    exp_rdata = shadow[ad];
    exp_instr = {shadow[af], shadow[af1]};
    starts.delete();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = ad;
    if_req = 1'b1; if_addr = af;
    k = 0;
    kd = 0;
    do begin
      @(negedge clk);
      k++;
      if (d_ack === 1'b1) begin kd = k; d_req = 1'b0; end
    end while (!if_ack && k < 80);
    if_req = 1'b0;
    checks++;
    if (kd != nd) begin errors++; $display("FAIL contention d_ack: got c%0d, required c%0d", kd, nd); end
    checks++;
    if (k != nf) begin errors++; $display("FAIL contention if_ack: got c%0d, required c%0d", k, nf); end
    checks++;
    if (d_rdata !== exp_rdata || if_instr !== exp_instr) begin
      errors++; $display("FAIL contention data: got %h/%h, required %h/%h", d_rdata, if_instr, exp_rdata, exp_instr);
    end
    checks++;
    if (starts.size() != 3 || starts[0] !== {1'b1, ad} || starts[1] !== {1'b1, af}) begin
      errors++; $display("FAIL contention order: got %0d strobes first=%h, required 3 starting %h", starts.size(),
                         starts.size() > 0 ? starts[0] : 9'h0, {1'b1, ad});
    end
  endtask

  task automatic test_wrap();
    run("fetch255", 1'b1, 1'b0, 8'd255, 16'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run("random", ($urandom % 3) == 0, $urandom % 2, 8'($urandom), 16'($urandom));
  endtask

  task automatic test_error();
    int k;
    logic err16;
    hang = 1'b1;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'd0;
    k = 0;
    err16 = 1'bx;
    do begin
      @(negedge clk);
      k++;
      if (k == 16) err16 = err;
    end while (!d_ack && k < 60);
    d_req = 1'b0;
    hang = 1'b0;
    checks++;
    if (k != 17) begin errors++; $display("FAIL timeout ack: got c%0d, required c17", k); end
    checks++;
    if (err16 !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL timeout err: got %b then %b, required 0 then 1", err16, err);
    end
    checks++;
    if (d_rdata !== exp_rdata) begin errors++; $display("FAIL timeout d_rdata: got %h, required %h", d_rdata, exp_rdata); end
    repeat (6) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err sticky: got %b, required 1", err); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = '0;
    exp_instr = '0;
    check_outputs("err reset");
  endtask

  task automatic test_reset_mid();
    int acks;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'd3;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_start !== 1'b0) begin
      errors++; $display("FAIL mid wait: busy=%b start=%b, required 1 0", busy, mem_start);
    end
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_outputs("mid reset");
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_ack || d_ack || busy) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL mid reset ack: got %0d active cycles, required 0", acks); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      shadow[i] = 16'($urandom);
      mem[i] = shadow[i];
    end
    shadow[0] = 16'h6884; mem[0] = 16'h6884;
    shadow[1] = 16'h0004; mem[1] = 16'h0004;
    shadow[245] = 16'h0008; mem[245] = 16'h0008;
    test_reset();
    test_fetch();
    test_data();
    test_contention();
    test_wrap();
    test_random();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Bus initiator on the CPU side of the 256x16 memory's start/ready handshake.
- Arbitrates between two clients: the instruction-fetch port and the load/store data port.
- Each instruction is two 16-bit words. A fetch issues two sequential reads and returns one 32-bit instruction. A data access is one 16-bit read or write.

Parameters:
- AW, 8, memory address width.
- DW, 16, memory word width.
- TIMEOUT, 15, maximum WAIT cycles per word before the error abort.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  AW  fetch address (low word).
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_instr  out  2*DW  fetched instruction; {word@addr, word@addr+1}, with the first word in [31:16].
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_rdata  out  DW  read data; valid from d_ack onward.
- mem_start  out  1  start strobe to memory.
- mem_rwn  out  1  1 = read, 0 = write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_ready  in  1  memory idle / previous access complete.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (synchronous): state=IDLE; mem_start=0; mem_rwn=1; mem_addr=0; mem_wdata=0; acks=0; if_instr=0; d_rdata=0; err=0; timeout counter=0. Reset mid-access abandons the access. No ack is produced. The memory is reset by the same reset.
- States: IDLE, ISSUE, WAIT, ACK. A word index (0/1) and a kind flag (FETCH/DATA) are registered.
- IDLE arbitration:
  - d_req wins over if_req.
  - On acceptance, latch addr, we, wdata and kind; set word index=0; go to ISSUE.
  - When both requests are pending, the fetch is served after the data ACK. The fetch is re-sampled in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_start=1.
  - mem_addr = latched address + word index, modulo 2^AW (255+1 wraps to 0).
  - mem_rwn = ~we for DATA; 1 for FETCH.
  - Enter ISSUE only when mem_ready=1; otherwise hold mem_start=0 until it is.
- WAIT:
  - mem_start=0; address and data outputs are held.
  - The memory drops ready the cycle after ISSUE. The first WAIT cycle with mem_ready=1 is the completion cycle: capture mem_rdata at that edge.
  - Against the memory this yields address[1:0]+2 WAIT cycles per word.
  - FETCH word 0: store into if_instr[31:16], set index=1, go to ISSUE.
  - FETCH word 1: store into if_instr[15:0], go to ACK.
  - DATA read: store into d_rdata, go to ACK. DATA write: go to ACK; d_rdata is unchanged.
- Timeout:
  - The counter clears in ISSUE and increments each WAIT cycle.
  - On reaching TIMEOUT with mem_ready still 0: set err=1 and go to ACK. Captured data for the aborted word is unchanged.
- ACK (1 cycle): pulse if_ack or d_ack according to kind, then go to IDLE.
- Per-word latency: 1 (ISSUE) + a+2 (WAIT) cycles, where a = mem_addr[1:0].
- Counting from the request-sampled IDLE cycle c0, ack lands at:
  - DATA: cycle a+4.
  - FETCH: cycle a0+a1+7.
- Requests deasserted before ack: the accepted access still completes and acks. The client must ignore the ack.

Test Plan:
1. Bench setup: block wired to the team's 256x16 memory model, preloaded 0:0x6884, 1:0x0004.
2. Fetch: reset, then if_req with if_addr=0 at c0 -> if_ack at c8, if_instr=0x68840004, busy high c1..c8.
3. Data read: d_req, d_we=0, d_addr=245 (holds 0x0008) -> d_ack at c5, d_rdata=0x0008, mem_rwn=1 during ISSUE.
4. Write then read: d_we=1, d_addr=3, d_wdata=0xBEEF -> d_ack at c7. A following read of address 3 returns 0xBEEF. if_instr is unchanged.
5. Contention and wrap:
   - if_req and d_req in the same cycle -> d_ack first; the fetch starts in the next IDLE.
   - if_addr=255 -> second read at address 0.
6. Error and reset:
   - mem_ready tied low after ISSUE -> err=1 after 15 WAIT cycles; ack pulses; err stays until reset.
   - reset asserted during WAIT -> IDLE next cycle, no ack, all outputs at reset values.
